oai_sweep_ctrl: RTL
===================

Name: oai_sweep_ctrl

Overview:
- Sequencer that drives the shared 3-bit stimulus (a, b, c) into NUM_DUT parallel OAI gate implementations and checks each output against the golden function y = ~((a | b) & c).
- Steps through all 8 input vectors and waits a programmable settle time per vector. Samples every DUT output, then reports a per-DUT sticky fail mask, a mismatch count and pass/done.
- Sits between the board/test harness and the gate instances, replacing free-running toggle stimulus with a deterministic, self-checking sweep.

Parameters:
- NUM_DUT, 3, number of OAI implementations checked in parallel; legal 1..16.
- SETTLE_CYCLES, 4, clock cycles stimulus is held before sampling; legal 1..255, 0 is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  cancels a running sweep.
- dut_y  input  NUM_DUT  outputs of the OAI instances; bit i belongs to DUT i.
- a  output  1  stimulus bit 2, registered.
- b  output  1  stimulus bit 1, registered.
- c  output  1  stimulus bit 0, registered.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high while in DONE.
- pass  output  1  high in DONE when fail_mask == 0; 0 elsewhere.
- fail_mask  output  NUM_DUT  sticky per-DUT mismatch flags.
- err_count  output  8  total mismatches in the current or last sweep, saturating at 255.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), from any state including mid-sweep:
  - State goes to IDLE.
  - a=b=c=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
  - Internal vector index and settle counter are cleared.
- State IDLE:
  - With start=1: load vector index 0, drive {a,b,c}=pattern(0), clear fail_mask and err_count, clear the settle counter, go to SETTLE.
- State SETTLE:
  - The settle counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE.
- State SAMPLE (one cycle):
  - For each i, if dut_y[i] != ~((a|b)&c), set fail_mask[i] and increment err_count by one, saturating.
  - Multiple DUTs failing in the same SAMPLE add the number of failing bits.
  - If the vector index == 7, go to DONE.
  - Otherwise increment the index, drive pattern(index+1), clear the counter and go to SETTLE.
- State DONE:
  - done=1; pass = (fail_mask == 0).
  - Outputs a, b, c hold the last vector.
  - With start=1, begin a new sweep exactly as from IDLE.
- Default pattern(n) is binary: {a,b,c} = n, i.e. the order 000, 001, …, 111.
- Latency: the first vector is on a/b/c the cycle after start is accepted.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE is entered 8*(SETTLE_CYCLES+1) cycles after the start edge (40 with defaults).
- start while busy: ignored, with no effect on state or results.
- abort=1 while busy: go to IDLE next edge and set a=b=c=0.
  - done and pass stay 0.
  - fail_mask and err_count keep their partial values.
- abort in IDLE or DONE: no effect.
- If start and abort are both 1: abort wins when busy; start wins in IDLE or DONE.
- Reset has priority over abort, which has priority over start.
- Golden comparison always uses the registered a, b, c, so no combinational path exists from start to a compare.

Optional Feature:
- Macro: OAI_SWEEP_GRAY_EN.
- Defined: pattern(n) is the 3-bit Gray code of n, giving the order 000, 001, 011, 010, 110, 111, 101, 100.
  - Exactly one stimulus bit toggles per step, which avoids multi-input transition hazards at the DUTs.
- Undefined: binary order.
- Timing, checking and all other behaviour are identical in both builds.

Test Plan:
- All DUTs bench-modelled as correct, defaults: pulse start.
  - a/b/c step 000…111, with each vector held 5 cycles.
  - done=1 at cycle 40; pass=1, err_count=0, fail_mask=3'b000.
- dut_y[1] stuck at 0, others correct.
  - The golden output is 1 for vectors 0, 1, 2, 4, 6.
  - Expect err_count=5, fail_mask=3'b010, pass=0.
- dut_y[2] inverted and dut_y[1] stuck at 0.
  - Expect err_count=13, fail_mask=3'b110.
  - Then pulse start from DONE: err_count is cleared to 0 on the next edge and a new sweep runs.
- Pulse start again at cycle 7 while busy: ignored; the sweep still ends at cycle 40.
  - Pulse abort at cycle 12: next edge gives IDLE, a=b=c=0, busy=0, done=0.
- Drive rst_n=0 for one edge at cycle 20 mid-sweep: all outputs at reset values.
  - Drive start again: a full 40-cycle sweep completes with pass=1.
- Build with OAI_SWEEP_GRAY_EN and all DUTs correct.
  - Stimulus order is 000, 001, 011, 010, 110, 111, 101, 100, with exactly one bit change per step.
  - pass=1 at cycle 40.

Source files
------------

// File: rtl/oai_sweep_if.sv
// ---------------------------------------------------------------------------
// oai_sweep_if : handshake, stimulus and result bundle for oai_sweep_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface oai_sweep_if #(
  parameter int NUM_DUT = 3
);
  logic                start;
  logic                abort;
  logic [NUM_DUT-1:0]  dut_y;
  logic                a;
  logic                b;
  logic                c;
  logic                busy;
  logic                done;
  logic                pass;
  logic [NUM_DUT-1:0]  fail_mask;
  logic [7:0]          err_count;

  // Harness side: requests sweeps and returns the gate outputs
  modport master (
    output start, abort, dut_y,
    input  a, b, c, busy, done, pass, fail_mask, err_count
  );

  // Controller side
  modport slave (
    input  start, abort, dut_y,
    output a, b, c, busy, done, pass, fail_mask, err_count
  );
endinterface

`default_nettype wire

// File: rtl/oai_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// oai_sweep_ctrl : sweeps all 8 (a,b,c) vectors into NUM_DUT OAI gates and
// checks each against ~((a|b)&c). Optional macro OAI_SWEEP_GRAY_EN: Gray order.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module oai_sweep_ctrl #(
  parameter int NUM_DUT       = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  oai_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic logic [2:0] pattern(input logic [2:0] n);
`ifdef OAI_SWEEP_GRAY_EN
    return n ^ {1'b0, n[2:1]};
`else
    return n;
`endif
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [2:0]          abc_q, abc_d;
  logic [NUM_DUT-1:0]  fail_q, fail_d;
  logic [7:0]          err_q, err_d;

  logic                golden;
  logic [NUM_DUT-1:0]  mism;
  logic [4:0]          n_fail;
  logic [8:0]          err_sum;
  logic [7:0]          err_sat;

  // Golden compare only sees the registered stimulus
  always_comb begin
    golden = ~((abc_q[2] | abc_q[1]) & abc_q[0]);
    mism   = bus.dut_y ^ {NUM_DUT{golden}};
    n_fail = 5'd0;
    for (int i = 0; i < NUM_DUT; i++) begin
      n_fail = n_fail + {4'd0, mism[i]};
    end
    err_sum = {1'b0, err_q} + {4'd0, n_fail};
    err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    fail_d  = fail_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          abc_d   = pattern(3'd0);
          fail_d  = '0;
          err_d   = 8'd0;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        fail_d = fail_q | mism;
        err_d  = err_sat;
        if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          abc_d   = pattern(idx_q + 3'd1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides any sweep progress but keeps partial results
    if (bus.abort && (state_q == S_SETTLE || state_q == S_SAMPLE)) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      cnt_d   = 8'd0;
      abc_d   = 3'd0;
      fail_d  = fail_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      abc_q   <= 3'd0;
      fail_q  <= '0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign bus.a         = abc_q[2];
  assign bus.b         = abc_q[1];
  assign bus.c         = abc_q[0];
  assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = (state_q == S_DONE) && (fail_q == '0);
  assign bus.fail_mask = fail_q;
  assign bus.err_count = err_q;

endmodule

`default_nettype wire
